frost32_mem_responder: RTL and testbench

//  Memory-side responder for the Frost32 CPU data port. It is the slave end of
//  the CPU's req_mem_access/addr/data/access-type/access-size request and drives
//  the CPU's data and wait_for_mem inputs back.
//  It holds a word-organised RAM and serves 32/16/8-bit reads and writes with a

---
 rtl/frost32_mem_responder.sv | 147 ++++++++++++++
 tb/tb_frost32_mem_responder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/frost32_mem_responder.sv
// Frost32 data-port memory responder: word-organised RAM serving 32/16/8-bit
// reads and writes with a fixed latency and a one-cycle illegal-access pulse.
module frost32_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req_mem_access,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic        in_access_type,
  input  logic [1:0]  in_access_size,
  output logic [31:0] out_data,
  output logic        out_wait_for_mem,
  output logic        out_access_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {StIdle, StBusy} state_t;

  state_t state, state_next;

  logic [3:0]    cnt;
  logic [AW+1:0] addr_q;
  logic [31:0]   data_q;
  logic          type_q;
  logic [1:0]    size_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          capture;
  logic          done;
  logic          illegal;
  logic [AW-1:0] word_idx;
  logic [3:0]    byte_mask;
  logic [31:0]   wdata;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_fmt;
  logic          unused_addr_hi;

  // Address bits above the RAM size simply wrap, so they are intentionally dropped.
  assign unused_addr_hi = ^in_addr[31:AW+2];

  assign capture  = (state == StIdle) && in_req_mem_access;
  assign done     = (state == StBusy) && (cnt == 4'd0);
  assign word_idx = addr_q[AW+1:2];

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= StIdle;
    else     state <= state_next;
  end

  // Next-state logic: idle until a request, busy until the latency counter expires.
  always_comb begin
    state_next = state;
    case (state)
      StIdle: if (in_req_mem_access) state_next = StBusy;
      StBusy: if (cnt == 4'd0)       state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  // FSM output: the CPU stalls for exactly the time spent in the busy state.
  always_comb begin
    out_wait_for_mem = (state == StBusy);
  end

  // Request capture and latency countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 4'd0;
      addr_q <= '0;
      data_q <= 32'd0;
      type_q <= 1'b0;
      size_q <= 2'd0;
    end else if (capture) begin
      cnt    <= 4'(LATENCY - 1);
      addr_q <= in_addr[AW+1:0];
      data_q <= in_data;
      type_q <= in_access_type;
      size_q <= in_access_size;
    end else if ((state == StBusy) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Alignment check, lane mask and lane-replicated write data for the latched request.
  always_comb begin
    illegal   = 1'b0;
    byte_mask = 4'b0000;
    wdata     = data_q;
    case (size_q)
      2'd0: begin
        illegal   = (addr_q[1:0] != 2'b00);
        byte_mask = 4'b1111;
      end
      2'd1: begin
        illegal   = addr_q[0];
        byte_mask = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{data_q[15:0]}};
      end
      2'd2: begin
        byte_mask = 4'b0001 << addr_q[1:0];
        wdata     = {4{data_q[7:0]}};
      end
      default: illegal = 1'b1;
    endcase
  end

  // Byte-masked RAM write at the completing edge; illegal or reset-aborted writes are dropped.
  always_ff @(posedge clk) begin
    if (!rst && done && type_q && !illegal) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_mask[k]) mem[word_idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Read-side lane extraction, zero-extended; sign extension is left to the CPU.
  always_comb begin
    rd_word  = mem[word_idx];
    rd_shift = rd_word >> {addr_q[1:0], 3'b000};
    rd_fmt   = 32'd0;
    case (size_q)
      2'd0:    rd_fmt = rd_word;
      2'd1:    rd_fmt = {16'd0, rd_shift[15:0]};
      2'd2:    rd_fmt = {24'd0, rd_shift[7:0]};
      default: rd_fmt = 32'd0;
    endcase
  end

  // Registered results: read data holds until the next read completes, error is a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data       <= 32'd0;
      out_access_err <= 1'b0;
    end else begin
      out_access_err <= done && illegal;
      if (done && !type_q) out_data <= illegal ? 32'd0 : rd_fmt;
    end
  end

endmodule

// File: tb/tb_frost32_mem_responder.sv
// Directed self-checking bench for frost32_mem_responder, with a LATENCY=2 and
// a LATENCY=1 instance sharing the same request inputs.
module tb_frost32_mem_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        acc_type;
  logic [1:0]  acc_size;

  logic [31:0] data_slow, data_fast;
  logic        wait_slow, wait_fast;
  logic        err_slow, err_fast;

  int checkCount;
  int passCount;

  frost32_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .in_req_mem_access(req), .in_addr(addr),
    .in_data(wdata), .in_access_type(acc_type), .in_access_size(acc_size),
    .out_data(data_slow), .out_wait_for_mem(wait_slow), .out_access_err(err_slow)
  );

  frost32_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut_fast (
    .clk(clk), .rst(rst), .in_req_mem_access(req), .in_addr(addr),
    .in_data(wdata), .in_access_type(acc_type), .in_access_size(acc_size),
    .out_data(data_fast), .out_wait_for_mem(wait_fast), .out_access_err(err_fast)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // One complete access: present the request for a single capture cycle, then
  // count stall cycles and sample data/error in the first non-stalled cycle.
  task automatic applyStimulus(input bit fast, input logic [31:0] a, input logic [31:0] d,
                               input logic wr, input logic [1:0] sz,
                               output logic [31:0] rdata, output logic err, output int waits);
    @(negedge clk);
    req = 1'b1; addr = a; wdata = d; acc_type = wr; acc_size = sz;
    @(negedge clk);
    req = 1'b0;
    waits = 0;
    while ((fast ? wait_fast : wait_slow) && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    rdata = fast ? data_fast : data_slow;
    err   = fast ? err_fast : err_slow;
  endtask

  logic [31:0] rd;
  logic        er;
  int          wt;
  logic [8:0]  pattern;

  initial begin
    checkCount = 0; passCount = 0;
    rst = 1'b1; req = 1'b0; addr = 32'd0; wdata = 32'd0; acc_type = 1'b0; acc_size = 2'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_data", data_slow, 32'd0);
    checkOutput("reset_wait", {31'd0, wait_slow}, 32'd0);
    checkOutput("reset_err",  {31'd0, err_slow}, 32'd0);
    rst = 1'b0;

    $display("[TB] basic word write/read");
    applyStimulus(0, 32'h10, 32'hDEADBEEF, 1'b1, 2'd0, rd, er, wt);
    checkOutput("t1_wr_waits", 32'(wt), 32'd2);
    checkOutput("t1_wr_err", {31'd0, er}, 32'd0);
    applyStimulus(0, 32'h10, 32'h0, 1'b0, 2'd0, rd, er, wt);
    checkOutput("t1_rd_waits", 32'(wt), 32'd2);
    checkOutput("t1_rd_data", rd, 32'hDEADBEEF);

    $display("[TB] byte lanes");
    applyStimulus(0, 32'h20, 32'h11223344, 1'b1, 2'd0, rd, er, wt);
    checkOutput("t2_write_holds_data", rd, 32'hDEADBEEF);
    applyStimulus(0, 32'h21, 32'hFFFFFFAA, 1'b1, 2'd2, rd, er, wt);
    applyStimulus(0, 32'h22, 32'hFFFFBBCC, 1'b1, 2'd1, rd, er, wt);
    checkOutput("t2_half_wr_err", {31'd0, er}, 32'd0);
    applyStimulus(0, 32'h20, 32'h0, 1'b0, 2'd0, rd, er, wt);
    checkOutput("t2_word", rd, 32'hBBCCAA44);
    applyStimulus(0, 32'h23, 32'h0, 1'b0, 2'd2, rd, er, wt);
    checkOutput("t2_byte3", rd, 32'h000000BB);
    applyStimulus(0, 32'h22, 32'h0, 1'b0, 2'd1, rd, er, wt);
    checkOutput("t2_half_hi", rd, 32'h0000BBCC);
    applyStimulus(0, 32'h21, 32'h0, 1'b0, 2'd2, rd, er, wt);
    checkOutput("t2_byte1", rd, 32'h000000AA);

    $display("[TB] illegal accesses");
    applyStimulus(0, 32'h30, 32'hCAFEF00D, 1'b1, 2'd0, rd, er, wt);
    applyStimulus(0, 32'h31, 32'h00001234, 1'b1, 2'd1, rd, er, wt);
    checkOutput("t3_mis16_err", {31'd0, er}, 32'd1);
    checkOutput("t3_mis16_waits", 32'(wt), 32'd2);
    applyStimulus(0, 32'h32, 32'h0, 1'b0, 2'd0, rd, er, wt);
    checkOutput("t3_mis32_err", {31'd0, er}, 32'd1);
    checkOutput("t3_mis32_data", rd, 32'd0);
    @(negedge clk);
    checkOutput("t3_err_pulse", {31'd0, err_slow}, 32'd0);
    applyStimulus(0, 32'h30, 32'h0, 1'b0, 2'd0, rd, er, wt);
    checkOutput("t3_ram_kept", rd, 32'hCAFEF00D);
    checkOutput("t3_ok_err", {31'd0, er}, 32'd0);
    applyStimulus(0, 32'h30, 32'h0, 1'b0, 2'd3, rd, er, wt);
    checkOutput("t3_bad_err", {31'd0, er}, 32'd1);
    checkOutput("t3_bad_data", rd, 32'd0);

    $display("[TB] back-to-back reads");
    @(negedge clk);
    req = 1'b1; addr = 32'h20; acc_type = 1'b0; acc_size = 2'd0;
    pattern = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pattern[i] = wait_slow;
      if (i == 6) req = 1'b0;
    end
    checkOutput("t4_pattern", {23'd0, pattern}, {23'd0, 9'b011011011});
    checkOutput("t4_busy", 32'($countones(pattern)), 32'd6);
    checkOutput("t4_data", data_slow, 32'hBBCCAA44);

    $display("[TB] reset during write");
    applyStimulus(0, 32'h40, 32'h01020304, 1'b1, 2'd0, rd, er, wt);
    applyStimulus(0, 32'h10, 32'h0, 1'b0, 2'd0, rd, er, wt);
    @(negedge clk);
    req = 1'b1; addr = 32'h40; wdata = 32'h5A5A5A5A; acc_type = 1'b1; acc_size = 2'd0;
    @(negedge clk);
    req = 1'b0;
    checkOutput("t5_busy", {31'd0, wait_slow}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_rst_wait", {31'd0, wait_slow}, 32'd0);
    checkOutput("t5_rst_data", data_slow, 32'd0);
    checkOutput("t5_rst_err", {31'd0, err_slow}, 32'd0);
    applyStimulus(0, 32'h40, 32'h0, 1'b0, 2'd0, rd, er, wt);
    checkOutput("t5_old_value", rd, 32'h01020304);

    $display("[TB] address wrap at latency 1");
    applyStimulus(1, 32'h1000, 32'h13579BDF, 1'b1, 2'd0, rd, er, wt);
    checkOutput("t6_wr_waits", 32'(wt), 32'd1);
    applyStimulus(1, 32'h0, 32'h0, 1'b0, 2'd0, rd, er, wt);
    checkOutput("t6_rd_waits", 32'(wt), 32'd1);
    checkOutput("t6_wrap_data", rd, 32'h13579BDF);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
